// File: rtl/key_event_ctrl_if.sv
// Register-bridge bus between the CPU side and key_event_ctrl.
// Ports: addr/rd/we/wdata driven by the master (CPU); rdata/irq driven by the slave (device).
// rdata is combinational in the slave; irq is a level interrupt.
interface key_event_ctrl_if;
  logic [1:0]  addr;
  logic        rd;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, rd, we, wdata, input rdata, irq);
  modport slave  (input addr, rd, we, wdata, output rdata, irq);
endinterface

// File: rtl/key_event_ctrl.sv
// Debounces 8 active-low keys, round-robin arbitrates press events into a small FIFO, 4-word CPU register bridge.
// Latency: raw fall -> stable after DB_LIMIT+2 cycles -> pending +1 -> FIFO +1; rdata combinational.
// Backpressure: none toward keys; a grant into a full FIFO without a same-cycle pop is dropped and sets ovf.
// Ports: clk, rst (sync, active-low), user_key[7:0] raw pins; bus (slave): addr, rd, we, wdata, rdata, irq.
module key_event_ctrl #(
  parameter int DB_LIMIT   = 1000000,
  parameter int DB_W       = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       user_key,
  key_event_ctrl_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LIMIT - 1);

  logic [7:0]      r_sync1, r_sync2;
  logic [7:0]      r_stable, r_stable_d;
  logic [DB_W-1:0] r_cnt [8];
  logic [7:0]      r_pending;
  logic [2:0]      r_ptr;
  logic [2:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic            r_irq_en, r_ovf;

  logic            w_gnt_vld;
  logic [2:0]      w_gnt_idx;
  logic [7:0]      w_gnt_mask;
  logic [7:0]      w_fall;
  logic            w_full, w_empty, w_pop, w_push, w_drop, w_ctrl_wr;
  logic            w_unused;

  // Round-robin: first pending key at ptr+1, ptr+2, ... wrapping; offset 8 lands back on ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_ptr;
    for (int k = 1; k <= 8; k++) begin
      if (!w_gnt_vld && r_pending[r_ptr + 3'(k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = r_ptr + 3'(k);
      end
    end
  end

  assign w_gnt_mask = w_gnt_vld ? (8'b1 << w_gnt_idx) : 8'b0;
  // Press = accepted level went 1->0 on the previous edge.
  assign w_fall     = r_stable_d & ~r_stable;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = bus.rd && (bus.addr == 2'd0) && !w_empty;
  // A pop in the same cycle frees the slot, so a grant into a full FIFO is still accepted.
  assign w_push     = w_gnt_vld && (!w_full || w_pop);
  assign w_drop     = w_gnt_vld && w_full && !w_pop;
  assign w_ctrl_wr  = bus.we && (bus.addr == 2'd1);
  assign w_unused   = &{1'b0, bus.wdata[31:2]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1    <= 8'hff;
      r_sync2    <= 8'hff;
      r_stable   <= 8'hff;
      r_stable_d <= 8'hff;
      r_pending  <= '0;
      r_ptr      <= 3'd7;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_irq_en   <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= user_key;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      // Set wins over grant-clear, so a press landing on its own grant cycle stays pending.
      r_pending <= (r_pending & ~w_gnt_mask) | w_fall;
      if (w_gnt_vld) r_ptr <= w_gnt_idx;
      if (w_push)    r_tail <= r_tail + 1'b1;
      if (w_pop)     r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_ctrl_wr) r_irq_en <= bus.wdata[0];
      // Overflow in the same cycle beats the write-1-to-clear.
      if (w_drop)                           r_ovf <= 1'b1;
      else if (w_ctrl_wr && bus.wdata[1])   r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_tail] <= w_gnt_idx;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0: if (!w_empty) bus.rdata = {23'b0, 1'b1, 5'b0, r_mem[r_head]};
      2'd1: bus.rdata = {30'b0, r_ovf, r_irq_en};
      2'd2: bus.rdata = {24'b0, r_stable};
      default: bus.rdata = {{(32-CW){1'b0}}, r_count};
    endcase
  end

  assign bus.irq = r_irq_en & (!w_empty | r_ovf);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl with DB_LIMIT=16, FIFO_DEPTH=4: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_key_event_ctrl;
  localparam int DB = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] user_key = 8'hff;
  int checks = 0;
  int errors = 0;

  key_event_ctrl_if bus();

  key_event_ctrl #(.DB_LIMIT(DB), .DB_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .user_key(user_key), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_s1, m_s2, m_stable, m_stable_d, m_pend;
  int         m_run [8];
  int         m_ptr;
  int         m_q [$];
  bit         m_irq_en, m_ovf;
  int         g, osz;
  bit         mpop;
  logic [7:0] nstable, npend;

  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = 8'hff; m_s2 = 8'hff; m_stable = 8'hff; m_stable_d = 8'hff; m_pend = 8'h00;
      m_ptr = 7; m_q.delete(); m_irq_en = 0; m_ovf = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      osz  = m_q.size();
      mpop = (bus.rd === 1'b1) && (bus.addr == 2'd0) && (osz > 0);
      g = -1;
      for (int k = 1; k <= 8; k++)
        if (g < 0 && m_pend[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
      npend = m_pend;
      if (g >= 0) begin npend[g] = 1'b0; m_ptr = g; end
      npend = npend | (m_stable_d & ~m_stable);
      if (mpop) void'(m_q.pop_front());
      if (bus.we === 1'b1 && bus.addr == 2'd1) begin
        m_irq_en = bus.wdata[0];
        if (bus.wdata[1]) m_ovf = 0;
      end
      if (g >= 0) begin
        if (osz < DEPTH || mpop) m_q.push_back(g);
        else m_ovf = 1;
      end
      nstable = m_stable;
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else if (m_run[i] == DB - 1) begin nstable[i] = m_s2[i]; m_run[i] = 0; end
        else m_run[i]++;
      end
      m_pend = npend; m_stable_d = m_stable; m_stable = nstable;
      m_s2 = m_s1; m_s1 = user_key;
    end
  end

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0: m_rdata = (m_q.size() > 0) ? (32'h100 | 32'(m_q[0])) : 32'h0;
      2'd1: m_rdata = {30'b0, m_ovf, m_irq_en};
      2'd2: m_rdata = {24'b0, m_stable};
      default: m_rdata = 32'(m_q.size());
    endcase
  endfunction

  function automatic logic m_irq();
    m_irq = m_irq_en && (m_q.size() != 0 || m_ovf);
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a; #1; d = bus.rdata; @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.addr = a; bus.wdata = v; bus.we = 1'b1; @(negedge clk); bus.we = 1'b0;
  endtask

  task automatic pop();
    bus.addr = 2'd0; bus.rd = 1'b1; @(negedge clk); bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; step(2); rst = 1'b1;
  endtask

  task automatic press(input int k, input int hold);
    user_key[k] = 1'b0; step(hold); user_key[k] = 1'b1; step(25);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.irq); end
    rd_reg(2'd0, d); checks++; if (d !== 32'h0)  begin errors++; $display("FAIL rst_evt got %h exp 0", d); end
    rd_reg(2'd1, d); checks++; if (d !== 32'h0)  begin errors++; $display("FAIL rst_ctrl got %h exp 0", d); end
    rd_reg(2'd2, d); checks++; if (d !== 32'hff) begin errors++; $display("FAIL rst_state got %h exp ff", d); end
    rd_reg(2'd3, d); checks++; if (d !== 32'h0)  begin errors++; $display("FAIL rst_count got %h exp 0", d); end
  endtask

  task automatic test_single_press();
    logic [31:0] d;
    wr(2'd1, 32'h1);
    user_key[3] = 1'b0; step(40);
    rd_reg(2'd3, d); checks++; if (d !== 32'd1)   begin errors++; $display("FAIL t1_count got %h exp 1", d); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL t1_irq got %b exp 1", bus.irq); end
    rd_reg(2'd0, d); checks++; if (d !== 32'h103) begin errors++; $display("FAIL t1_evt got %h exp 103", d); end
    pop();
    rd_reg(2'd3, d); checks++; if (d !== 32'd0)   begin errors++; $display("FAIL t1_count_pop got %h exp 0", d); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL t1_irq_pop got %b exp 0", bus.irq); end
    rd_reg(2'd2, d); checks++; if (d !== 32'hf7)  begin errors++; $display("FAIL t1_state got %h exp f7", d); end
    user_key[3] = 1'b1; step(25);
    rd_reg(2'd3, d); checks++; if (d !== 32'd0)   begin errors++; $display("FAIL t1_release_count got %h exp 0", d); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    for (int p = 0; p < 5; p++) begin
      user_key[5] = 1'b0; step(10); user_key[5] = 1'b1; step(5);
    end
    step(20);
    rd_reg(2'd2, d); checks++; if (d !== 32'hff) begin errors++; $display("FAIL t2_state got %h exp ff", d); end
    rd_reg(2'd3, d); checks++; if (d !== 32'd0)  begin errors++; $display("FAIL t2_count got %h exp 0", d); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL t2_irq got %b exp 0", bus.irq); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h100; exp_a[1] = 32'h105; exp_a[2] = 32'h106;
    do_reset();
    user_key = 8'b1001_1110; step(25); user_key = 8'hff;
    rd_reg(2'd3, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL t3_count got %h exp 3", d); end
    for (int i = 0; i < 3; i++) begin
      rd_reg(2'd0, d); checks++;
      if (d !== exp_a[i]) begin errors++; $display("FAIL t3_order%0d got %h exp %h", i, d, exp_a[i]); end
      pop();
    end
    step(25);
    user_key = 8'b1011_1110; step(25); user_key = 8'hff;
    rd_reg(2'd0, d); checks++; if (d !== 32'h100) begin errors++; $display("FAIL t3_wrap0 got %h exp 100", d); end
    pop();
    rd_reg(2'd0, d); checks++; if (d !== 32'h106) begin errors++; $display("FAIL t3_wrap1 got %h exp 106", d); end
    pop();
    step(25);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int keys [5];
    keys[0] = 1; keys[1] = 2; keys[2] = 3; keys[3] = 4; keys[4] = 7;
    wr(2'd1, 32'h1);
    for (int i = 0; i < 5; i++) press(keys[i], 25);
    rd_reg(2'd3, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL t4_count got %h exp 4", d); end
    rd_reg(2'd1, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL t4_ctrl got %h exp 3", d); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL t4_irq got %b exp 1", bus.irq); end
    wr(2'd1, 32'h3);
    rd_reg(2'd1, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL t4_ctrl_clr got %h exp 1", d); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL t4_irq_clr got %b exp 1", bus.irq); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'd0, d); checks++;
      if (d !== (32'h100 | 32'(keys[i]))) begin errors++; $display("FAIL t4_pop%0d got %h exp %h", i, d, 32'h100 | 32'(keys[i])); end
      pop();
    end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL t4_irq_empty got %b exp 0", bus.irq); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d;
    bit hit;
    bus.addr = 2'd0; bus.rd = 1'b1; #1; d = bus.rdata;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t5_empty_evt got %h exp 0", d); end
    @(negedge clk); bus.rd = 1'b0;
    rd_reg(2'd3, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL t5_empty_count got %h exp 0", d); end
    for (int k = 0; k < 4; k++) press(k, 25);
    user_key[4] = 1'b0;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (m_pend != 8'h00) begin hit = 1; pop(); end
      else step(1);
    end
    checks++; if (!hit) begin errors++; $display("FAIL t5_grant_timeout got none exp grant"); end
    rd_reg(2'd3, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL t5_count got %h exp 4", d); end
    rd_reg(2'd1, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL t5_ctrl got %h exp 1", d); end
    for (int i = 1; i <= 4; i++) begin
      rd_reg(2'd0, d); checks++;
      if (d !== (32'h100 | 32'(i))) begin errors++; $display("FAIL t5_pop%0d got %h exp %h", i, d, 32'h100 | 32'(i)); end
      pop();
    end
    user_key[4] = 1'b1; step(25);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit hit;
    do_reset();
    press(0, 25); press(1, 25);
    rd_reg(2'd3, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL t6_pre_count got %h exp 2", d); end
    user_key[2] = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (m_run[2] == 10) hit = 1;
      else step(1);
    end
    checks++; if (!hit) begin errors++; $display("FAIL t6_cnt_timeout got none exp count 10"); end
    rst = 1'b0; step(1); rst = 1'b1;
    rd_reg(2'd3, d); checks++; if (d !== 32'd0)  begin errors++; $display("FAIL t6_count got %h exp 0", d); end
    rd_reg(2'd2, d); checks++; if (d !== 32'hff) begin errors++; $display("FAIL t6_state got %h exp ff", d); end
    rd_reg(2'd1, d); checks++; if (d !== 32'h0)  begin errors++; $display("FAIL t6_ctrl got %h exp 0", d); end
    step(DB);
    rd_reg(2'd3, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL t6_early got %h exp 0", d); end
    rd_reg(2'd3, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL t6_late got %h exp 1", d); end
    user_key[2] = 1'b1; step(25);
  endtask

  task automatic test_random();
    int hold [8];
    logic [31:0] exp_d;
    logic exp_i;
    do_reset();
    for (int i = 0; i < 8; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (hold[i] == 0) begin
          user_key[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 8);
        end else hold[i]--;
      end
      bus.addr  = 2'($urandom_range(0, 3));
      bus.rd    = ($urandom_range(0, 5) == 0);
      bus.we    = ($urandom_range(0, 19) == 0);
      bus.wdata = $urandom;
      #1;
      exp_d = m_rdata(bus.addr);
      exp_i = m_irq();
      checks++; if (bus.rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata cyc %0d addr %0d got %h exp %h", c, bus.addr, bus.rdata, exp_d); end
      checks++; if (bus.irq !== exp_i)   begin errors++; $display("FAIL rnd_irq cyc %0d got %b exp %b", c, bus.irq, exp_i); end
      @(negedge clk);
    end
    bus.rd = 1'b0; bus.we = 1'b0; user_key = 8'hff; step(30);
  endtask

  initial begin
    bus.addr = 2'd0; bus.rd = 1'b0; bus.we = 1'b0; bus.wdata = 32'h0;
    step(2);
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
